// File: rtl/perf_pkg.sv
// Shared constants, types and helpers for the Wishbone latency monitor.
// Contents: register offsets, CTRL bit indices, FSM state type,
// saturating-add helpers used by the FSM and the statistics registers.
package perf_pkg;

    // Register offsets relative to BASE_ADR (word spaced).
    localparam logic [31:0] REG_TXN   = 32'h00;
    localparam logic [31:0] REG_SUM   = 32'h04;
    localparam logic [31:0] REG_MAX   = 32'h08;
    localparam logic [31:0] REG_MIN   = 32'h0C;
    localparam logic [31:0] REG_ABORT = 32'h10;
    localparam logic [31:0] REG_CTRL  = 32'h14;

    // CTRL register bit positions.
    localparam int CTRL_EN  = 0;
    localparam int CTRL_CLR = 1;
    localparam int CTRL_OVF = 8;

    localparam logic [31:0] SAT_MAX = 32'hFFFF_FFFF;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } lat_state_t;

    // Unsigned add clamped at all-ones.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? SAT_MAX : s[31:0];
    endfunction

    // High when the true sum does not fit, i.e. sat_add had to clamp.
    function automatic logic sat_ovf(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32];
    endfunction

endpackage

// File: rtl/wishbone.sv
// Wishbone bus bundle shared by masters, slaves and passive monitors.
// Signals: clk, rst, adr, dat_o (master write data), dat_i (slave read data),
// we, stb, cyc, ack, err, rty.
interface wishbone;
    logic        clk;
    logic        rst;
    logic [31:0] adr;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        we;
    logic        stb;
    logic        cyc;
    logic        ack;
    logic        err;
    logic        rty;

    modport master (
        input  clk, rst, dat_i, ack, err, rty,
        output adr, dat_o, we, stb, cyc
    );

    modport slave (
        input  clk, rst, adr, dat_o, we, stb, cyc,
        output dat_i, ack, err, rty
    );

    // Passive observer: only the handshake is of interest.
    modport monitor (
        input  cyc, stb, ack
    );
endinterface

// File: rtl/perf_lat_fsm.sv
// Monitor-side FSM: measures cycles from first strobe to ack per transaction.
// Ports: clk_i/rst_i, en_i (enable), clr_i (discard in-flight), cyc_i/stb_i/ack_i
// (observed bus); rec_valid_o/rec_lat_o report a completed transaction
// combinationally in its ack cycle, abort_pulse_o flags a dropped cycle.
module perf_lat_fsm
    import perf_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        clr_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        ack_i,
    output logic        rec_valid_o,
    output logic [31:0] rec_lat_o,
    output logic        abort_pulse_o
);

    lat_state_t  state_q, state_d;
    logic [31:0] lat_q, lat_d;
    logic        active;

    assign active = cyc_i & stb_i;

    always_comb begin
        state_d       = state_q;
        lat_d         = lat_q;
        rec_valid_o   = 1'b0;
        rec_lat_o     = 32'd1;
        abort_pulse_o = 1'b0;

        // Disable or clear throws away any in-flight measurement silently.
        if (!en_i || clr_i) begin
            state_d = IDLE;
            lat_d   = 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (active) begin
                        if (ack_i) begin
                            // Single-cycle transaction, no state change needed.
                            rec_valid_o = 1'b1;
                            rec_lat_o   = 32'd1;
                        end else begin
                            state_d = WAIT;
                            lat_d   = 32'd1;
                        end
                    end
                end
                WAIT: begin
                    if (active) begin
                        if (ack_i) begin
                            rec_valid_o = 1'b1;
                            rec_lat_o   = sat_add(lat_q, 32'd1);
                            state_d     = IDLE;
                            lat_d       = 32'd0;
                        end else begin
                            lat_d = sat_add(lat_q, 32'd1);
                        end
                    end else begin
                        abort_pulse_o = 1'b1;
                        state_d       = IDLE;
                        lat_d         = 32'd0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    lat_d   = 32'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            lat_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
        end
    end

endmodule

// File: rtl/perf_latency.sv
// Wishbone bus-latency monitor: per-transaction count, latency sum/min/max, aborts.
// Ports: wb (slave register access, zero-wait-state combinational ack/read),
// m (observed master bus, cyc/stb/ack only). Clock and reset come from wb.
module perf_latency
    import perf_pkg::*;
#(
    parameter logic [31:0] BASE_ADR = 32'h9900_0010,
    parameter logic        EN_RST   = 1'b1
)(
    wishbone.slave   wb,
    wishbone.monitor m
);

    logic [31:0] txn_q, txn_d;
    logic [31:0] sum_q, sum_d;
    logic [31:0] max_q, max_d;
    logic [31:0] min_q, min_d;
    logic [31:0] abort_q, abort_d;
    logic        en_q, en_d;
    logic        ovf_q, ovf_d;

    logic        acc;
    logic        ctrl_wr;
    logic        clr;
    logic        rec_vld;
    logic [31:0] rec_lat;
    logic        abort_pulse;

    assign acc     = wb.stb & wb.cyc;
    assign ctrl_wr = acc & wb.we & (wb.adr == BASE_ADR + REG_CTRL);
    assign clr     = ctrl_wr & wb.dat_o[CTRL_CLR];

    assign wb.ack = acc;
    assign wb.err = 1'b0;
    assign wb.rty = 1'b0;

    perf_lat_fsm u_fsm (
        .clk_i         (wb.clk),
        .rst_i         (wb.rst),
        .en_i          (en_q),
        .clr_i         (clr),
        .cyc_i         (m.cyc),
        .stb_i         (m.stb),
        .ack_i         (m.ack),
        .rec_valid_o   (rec_vld),
        .rec_lat_o     (rec_lat),
        .abort_pulse_o (abort_pulse)
    );

    // Statistics next-state; clear wins over a record/abort in the same cycle.
    always_comb begin
        txn_d   = txn_q;
        sum_d   = sum_q;
        max_d   = max_q;
        min_d   = min_q;
        abort_d = abort_q;
        en_d    = en_q;
        ovf_d   = ovf_q;

        if (ctrl_wr) begin
            en_d = wb.dat_o[CTRL_EN];
        end

        if (clr) begin
            txn_d   = 32'd0;
            sum_d   = 32'd0;
            max_d   = 32'd0;
            min_d   = SAT_MAX;
            abort_d = 32'd0;
            ovf_d   = 1'b0;
        end else begin
            if (rec_vld) begin
                txn_d = sat_add(txn_q, 32'd1);
                sum_d = sat_add(sum_q, rec_lat);
                if (rec_lat > max_q) max_d = rec_lat;
                if (rec_lat < min_q) min_d = rec_lat;
                if (sat_ovf(txn_q, 32'd1) || sat_ovf(sum_q, rec_lat)) ovf_d = 1'b1;
            end
            if (abort_pulse) begin
                abort_d = sat_add(abort_q, 32'd1);
                if (sat_ovf(abort_q, 32'd1)) ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge wb.clk or posedge wb.rst) begin
        if (wb.rst) begin
            txn_q   <= 32'd0;
            sum_q   <= 32'd0;
            max_q   <= 32'd0;
            min_q   <= SAT_MAX;
            abort_q <= 32'd0;
            en_q    <= EN_RST;
            ovf_q   <= 1'b0;
        end else begin
            txn_q   <= txn_d;
            sum_q   <= sum_d;
            max_q   <= max_d;
            min_q   <= min_d;
            abort_q <= abort_d;
            en_q    <= en_d;
            ovf_q   <= ovf_d;
        end
    end

    // Combinational read mux; the clear bit is a pulse and always reads 0.
    always_comb begin
        wb.dat_i = 32'd0;
        if (wb.adr == BASE_ADR + REG_TXN)        wb.dat_i = txn_q;
        else if (wb.adr == BASE_ADR + REG_SUM)   wb.dat_i = sum_q;
        else if (wb.adr == BASE_ADR + REG_MAX)   wb.dat_i = max_q;
        else if (wb.adr == BASE_ADR + REG_MIN)   wb.dat_i = min_q;
        else if (wb.adr == BASE_ADR + REG_ABORT) wb.dat_i = abort_q;
        else if (wb.adr == BASE_ADR + REG_CTRL) begin
            wb.dat_i[CTRL_EN]  = en_q;
            wb.dat_i[CTRL_OVF] = ovf_q;
        end
    end

endmodule

// File: tb/tb_perf_latency.sv
module tb_perf_latency;

    localparam logic [31:0] BASE = 32'h9900_0010;

    wishbone wb_if();
    wishbone mon_if();

    perf_latency #(.BASE_ADR(BASE), .EN_RST(1'b1)) dut (
        .wb (wb_if),
        .m  (mon_if)
    );

    initial wb_if.clk = 1'b0;
    always #5 wb_if.clk = ~wb_if.clk;
    assign mon_if.clk = wb_if.clk;
    assign mon_if.rst = wb_if.rst;

    typedef struct {
        int          phase;
        logic [31:0] off;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vt[$];
    int n_vec = 0;
    int n_err = 0;

    function automatic void add(int ph, logic [31:0] off, logic [31:0] exp, string nm);
        vec_t v;
        v.phase = ph; v.off = off; v.exp = exp; v.name = nm;
        vt.push_back(v);
    endfunction

    // Six-register expectation row for one phase.
    function automatic void add_row(int ph, logic [31:0] t, logic [31:0] s, logic [31:0] mx,
                                    logic [31:0] mn, logic [31:0] ab, logic [31:0] c);
        add(ph, 32'h00, t,  "TXN_CNT");
        add(ph, 32'h04, s,  "LAT_SUM");
        add(ph, 32'h08, mx, "LAT_MAX");
        add(ph, 32'h0C, mn, "LAT_MIN");
        add(ph, 32'h10, ab, "ABORT_CNT");
        add(ph, 32'h14, c,  "CTRL");
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    // Combinational read: no clock edge needed.
    task automatic wb_read(input logic [31:0] off, output logic [31:0] d, output logic a);
        wb_if.adr = BASE + off; wb_if.we = 1'b0; wb_if.stb = 1'b1; wb_if.cyc = 1'b1;
        #1;
        d = wb_if.dat_i;
        a = wb_if.ack;
        wb_if.stb = 1'b0; wb_if.cyc = 1'b0;
    endtask

    task automatic run_phase(int ph);
        logic [31:0] d;
        logic a;
        foreach (vt[i]) begin
            if (vt[i].phase == ph) begin
                wb_read(vt[i].off, d, a);
                chk($sformatf("p%0d %s", ph, vt[i].name), d, vt[i].exp);
            end
        end
    endtask

    task automatic wb_write_start(logic [31:0] off, logic [31:0] data);
        wb_if.adr = BASE + off; wb_if.dat_o = data; wb_if.we = 1'b1;
        wb_if.stb = 1'b1; wb_if.cyc = 1'b1;
    endtask

    task automatic wb_idle();
        wb_if.we = 1'b0; wb_if.stb = 1'b0; wb_if.cyc = 1'b0;
    endtask

    task automatic wb_write(logic [31:0] off, logic [31:0] data);
        @(negedge wb_if.clk);
        wb_write_start(off, data);
        @(negedge wb_if.clk);
        wb_idle();
    endtask

    task automatic mon_set(logic c, logic s, logic a);
        mon_if.cyc = c; mon_if.stb = s; mon_if.ack = a;
    endtask

    // One transaction of 'lat' strobe cycles, ack in the last, then one idle cycle.
    task automatic mon_txn(int lat);
        for (int i = 1; i <= lat; i++) begin
            @(negedge wb_if.clk);
            mon_set(1'b1, 1'b1, i == lat);
        end
        @(negedge wb_if.clk);
        mon_set(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] d;
        logic a;

        wb_if.rst = 1'b1;
        wb_if.adr = '0; wb_if.dat_o = '0; wb_if.we = 1'b0; wb_if.stb = 1'b0; wb_if.cyc = 1'b0;
        mon_if.adr = '0; mon_if.dat_o = '0; mon_if.dat_i = '0; mon_if.we = 1'b0;
        mon_if.err = 1'b0; mon_if.rty = 1'b0;
        mon_set(1'b0, 1'b0, 1'b0);

        add_row(0, 0, 0, 0, 32'hFFFF_FFFF, 0, 32'h1);
        add(0, 32'h18, 0, "unmapped+18");
        add(0, 32'hFFFF_FFFC, 0, "unmapped-4");
        add_row(1, 3, 9, 5, 1, 0, 32'h1);
        add_row(2, 4, 4, 1, 1, 0, 32'h1);
        add_row(3, 1, 2, 2, 2, 1, 32'h1);
        add_row(4, 0, 0, 0, 32'hFFFF_FFFF, 0, 32'h1);
        add_row(5, 0, 0, 0, 32'hFFFF_FFFF, 0, 32'h0);
        add_row(6, 1, 32'hFFFF_FFFF, 32'h20, 32'h20, 0, 32'h101);
        add_row(7, 0, 0, 0, 32'hFFFF_FFFF, 0, 32'h1);

        repeat (2) @(negedge wb_if.clk);
        wb_if.rst = 1'b0;
        @(negedge wb_if.clk);

        // Reset state and slave handshake.
        run_phase(0);
        wb_read(32'h0, d, a);
        chk("wb ack", {31'd0, a}, 32'd1);
        chk("wb err", {31'd0, wb_if.err}, 32'd0);
        chk("wb rty", {31'd0, wb_if.rty}, 32'd0);

        // Latencies 1, 3, 5 with idle gaps.
        mon_txn(1); mon_txn(3); mon_txn(5);
        run_phase(1);

        // Counter registers are read-only.
        wb_write(32'h00, 32'h1234_5678);
        wb_read(32'h00, d, a);
        chk("TXN_CNT ro", d, 32'd3);

        // Clear reads back as 0, then four back-to-back single-cycle acks.
        wb_write(32'h14, 32'h3);
        for (int i = 0; i < 4; i++) begin
            @(negedge wb_if.clk);
            mon_set(1'b1, 1'b1, 1'b1);
        end
        @(negedge wb_if.clk);
        mon_set(1'b0, 1'b0, 1'b0);
        run_phase(2);

        // Abort after two unacked cycles, then a two-cycle transaction.
        wb_write(32'h14, 32'h3);
        @(negedge wb_if.clk); mon_set(1'b1, 1'b1, 1'b0);
        @(negedge wb_if.clk); mon_set(1'b1, 1'b1, 1'b0);
        @(negedge wb_if.clk); mon_set(1'b0, 1'b0, 1'b0);
        mon_txn(2);
        run_phase(3);

        // Clear in the same cycle as a monitored ack: clear wins.
        mon_txn(2);
        @(negedge wb_if.clk); mon_set(1'b1, 1'b1, 1'b0);
        @(negedge wb_if.clk); mon_set(1'b1, 1'b1, 1'b0);
        @(negedge wb_if.clk); mon_set(1'b1, 1'b1, 1'b1); wb_write_start(32'h14, 32'h3);
        @(negedge wb_if.clk); mon_set(1'b0, 1'b0, 1'b0); wb_idle();
        run_phase(4);

        // Disabled: transactions are ignored.
        wb_write(32'h14, 32'h0);
        mon_txn(2);
        mon_txn(1);
        run_phase(5);
        wb_write(32'h14, 32'h1);

        // Saturation of LAT_SUM sets the sticky overflow flag.
        @(negedge wb_if.clk);
        dut.sum_q = 32'hFFFF_FFF0;
        mon_txn(32);
        run_phase(6);

        // Reset asserted mid-WAIT takes effect without a clock edge.
        @(negedge wb_if.clk); mon_set(1'b1, 1'b1, 1'b0);
        repeat (3) @(posedge wb_if.clk);
        #1;
        wb_if.rst = 1'b1;
        run_phase(7);
        mon_set(1'b0, 1'b0, 1'b0);
        @(negedge wb_if.clk);
        wb_if.rst = 1'b0;

        // After reset, a fresh single-cycle transaction records normally.
        mon_txn(1);
        wb_read(32'h00, d, a);
        chk("post-rst TXN", d, 32'd1);
        wb_read(32'h10, d, a);
        chk("post-rst ABORT", d, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/perf_latency.md
Name: perf_latency

Overview:
- Wishbone bus-latency monitor; sits beside perf_top on the same monitored master port.
- Where perf_top counts strobe and ack cycles, this block turns the same monitor stream into per-transaction figures:
  - completed transactions
  - summed latency
  - minimum and maximum latency
  - aborted cycles
- Software reads and controls it as a Wishbone slave in the 0x9900_00xx performance window.

Parameters:
- BASE_ADR, 32'h99000010, byte address of register 0; registers are word-spaced, 6 words.
- EN_RST, 1'b1, value of CTRL.enable after reset.

Ports:
- wb.clk  input  1  system clock; carried in the wishbone interface, as in the rest of the design.
- wb.rst  input  1  reset; asynchronous, active-high; carried in the wishbone interface.
- wb  slave  (wishbone.slave)  register access: adr 32, dat_o 32 (write data in), dat_i 32 (read data out), we, stb, cyc in; ack, err, rty out.
- m  monitor  (wishbone.monitor)  observed master bus; uses cyc, stb, ack only.

Behaviour:
- Slave handshake:
  - wb.ack = wb.stb & wb.cyc, combinational, zero wait states.
  - wb.err = 0 and wb.rty = 0, constant.
- Register map (offset from BASE_ADR), full 32-bit address compare:
  - 0x00 TXN_CNT: completed transactions; reset 0.
  - 0x04 LAT_SUM: sum of latencies; reset 0.
  - 0x08 LAT_MAX: reset 0.
  - 0x0C LAT_MIN: reset 32'hFFFFFFFF.
  - 0x10 ABORT_CNT: cycles dropped without ack; reset 0.
  - 0x14 CTRL: bit0 enable (RW), bit1 clear (write-1 pulse, reads 0), bit8 ovf sticky (RO); reset {ovf=0, enable=EN_RST}.
- Read path: wb.dat_i is a combinational mux on wb.adr; unmapped addresses return 0.
- Writes take effect when wb.stb & wb.cyc & wb.we are high on a clock edge.
  - Writes to offsets 0x00-0x10 are ignored.
- Latency definition: the number of cycles with m.cyc & m.stb high, up to and including the ack cycle. Minimum value is 1.
- FSM, states IDLE and WAIT, with internal 32-bit lat:
  - IDLE: if enable & m.cyc & m.stb & m.ack, record latency 1 and stay in IDLE.
  - IDLE: if enable & m.cyc & m.stb & !m.ack, set lat=1 and go to WAIT.
  - WAIT: if m.cyc & m.stb & m.ack, record lat+1 and go to IDLE.
  - WAIT: if m.cyc & m.stb & !m.ack, lat saturating-increments.
  - WAIT: if !(m.cyc & m.stb), ABORT_CNT++ and go to IDLE; nothing is recorded.
  - Back-to-back: a strobe held high in the cycle after an ack is a new transaction, detected in IDLE.
- Record(L), one update per completed transaction:
  - TXN_CNT++
  - LAT_SUM += L
  - LAT_MAX = max(LAT_MAX, L)
  - LAT_MIN = min(LAT_MIN, L)
  - All updates land on the clock edge after the ack cycle.
- Width and overflow rules:
  - Every counter and accumulator saturates at 32'hFFFFFFFF; there is no wrap.
  - Any saturation event sets ovf; ovf is cleared only by clear or reset.
- Clear (CTRL bit1 written 1):
  - Next edge: all statistics return to reset values, ovf=0, FSM forced to IDLE, any in-flight transaction discarded.
  - Clear has priority over a record or abort in the same cycle.
  - The enable field is written in the same access.
- enable=0:
  - FSM is forced to IDLE and any in-flight transaction is discarded, with no abort counted.
  - Statistics hold their values.
- Reset asserted mid-operation: immediate asynchronous return to all reset values and IDLE.

Decomposition:
- Package perf_pkg holds:
  - register offset constants (REG_TXN..REG_CTRL)
  - CTRL bit indices
  - typedef enum logic {IDLE, WAIT} lat_state_t
  - a saturating-add function
- Sub-module perf_lat_fsm: monitor-side FSM plus lat counter. Its outputs are rec_valid, rec_lat[31:0] and abort_pulse.
- The top level holds the statistics registers and the slave decode.

Test Plan:
- Reset, then read all six registers -> 0, 0, 0, FFFFFFFF, 0, 0x1 (ovf=0, enable=1).
- Three monitor transactions with acks at cycle 1, cycle 3 and cycle 5, idle gaps between them -> TXN_CNT=3, LAT_SUM=9, LAT_MAX=5, LAT_MIN=1.
- Back-to-back: stb held 4 cycles with ack on every cycle -> TXN_CNT=4, LAT_SUM=4, LAT_MIN=LAT_MAX=1.
- stb/cyc dropped after 2 cycles without ack, then one 2-cycle transaction -> ABORT_CNT=1, TXN_CNT=1, LAT_SUM=2.
- Write CTRL=0x3 in the same cycle as a monitored ack -> all statistics at reset values, TXN_CNT=0, enable=1; a write of CTRL=0x0 then a transaction -> no change.
- Force LAT_SUM to FFFFFFF0 via long transactions (or a bind preload), then add latency 0x20 -> LAT_SUM=FFFFFFFF, CTRL bit8=1.
- Assert wb.rst mid-WAIT -> outputs at reset values without a clock edge.
